div_seq_ctrl: RTL and testbench

//  Sequencer that sits between the EXE stage and the AXI-stream unsigned_div IP.

---
 rtl/div_seq_ctrl_pkg.sv | 20 ++
 rtl/div_seq_ctrl_sign_fix.sv | 13 +
 rtl/div_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the divider sequencer: datapath width, FSM state
// encodings and the operand sign helper.
package div_seq_ctrl_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [2:0] {
        DIV_ST_IDLE  = 3'd0,
        DIV_ST_SEND  = 3'd1,
        DIV_ST_WAIT  = 3'd2,
        DIV_ST_DONE  = 3'd3,
        DIV_ST_DRAIN = 3'd4
    } div_state_e;

    // An operand counts as negative only for a signed (DIV) request.
    function automatic logic operand_neg(input logic is_signed, input logic msb);
        return is_signed & msb;
    endfunction

endpackage

// File: rtl/div_seq_ctrl_sign_fix.sv
// Conditional two's-complement negate, used both for operand abs() and for
// result sign restoration. Negating the most negative value yields itself.
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_value
);

    assign o_value = i_neg ? (~i_value + {{(W-1){1'b0}}, 1'b1}) : i_value;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer between EXE and an AXI-stream unsigned divider IP.
// Optional feature macro: DIV_ZERO_BYPASS_EN (zero divisor skips the IP).
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    input  logic           req_signed,
    input  logic [W-1:0]   req_src1,
    input  logic [W-1:0]   req_src2,
    input  logic           res_ack,
    input  logic           flush,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic [W-1:0]   dvd_tdata,
    output logic           dvd_tvalid,
    input  logic           dvd_tready,
    output logic [W-1:0]   dvs_tdata,
    output logic           dvs_tvalid,
    input  logic           dvs_tready,
    input  logic [2*W-1:0] dout_tdata,
    input  logic           dout_tvalid
);

    div_state_e   r_state;
    div_state_e   w_next_state;

    logic         r_dvd_sent;
    logic         r_dvs_sent;
    logic         r_flushed;
    logic         r_sq;
    logic         r_sr;
    logic [W-1:0] r_dvd_data;
    logic [W-1:0] r_dvs_data;
    logic [W-1:0] r_quotient;
    logic [W-1:0] r_remainder;

    logic         w_s1;
    logic         w_s2;
    logic [W-1:0] w_dvd_abs;
    logic [W-1:0] w_dvs_abs;
    logic [W-1:0] w_q_fix;
    logic [W-1:0] w_r_fix;
    logic         w_dvd_hs;
    logic         w_dvs_hs;
    logic         w_dvd_done;
    logic         w_dvs_done;
    logic         w_bypass;
    logic         w_accept;
    logic         w_load_res;
    logic         w_set_flushed;

    assign w_s1 = operand_neg(req_signed, req_src1[W-1]);
    assign w_s2 = operand_neg(req_signed, req_src2[W-1]);

`ifdef DIV_ZERO_BYPASS_EN
    assign w_bypass = (req_src2 == '0);
`else
    assign w_bypass = 1'b0;
`endif

    div_sign_fix #(.W(W)) u_fix_dvd (
        .i_neg   (w_s1),
        .i_value (req_src1),
        .o_value (w_dvd_abs)
    );

    div_sign_fix #(.W(W)) u_fix_dvs (
        .i_neg   (w_s2),
        .i_value (req_src2),
        .o_value (w_dvs_abs)
    );

    div_sign_fix #(.W(W)) u_fix_quo (
        .i_neg   (r_sq),
        .i_value (dout_tdata[2*W-1:W]),
        .o_value (w_q_fix)
    );

    div_sign_fix #(.W(W)) u_fix_rem (
        .i_neg   (r_sr),
        .i_value (dout_tdata[W-1:0]),
        .o_value (w_r_fix)
    );

    assign dvd_tvalid = (r_state == DIV_ST_SEND) && !r_dvd_sent;
    assign dvs_tvalid = (r_state == DIV_ST_SEND) && !r_dvs_sent;
    assign dvd_tdata  = r_dvd_data;
    assign dvs_tdata  = r_dvs_data;

    assign w_dvd_hs   = dvd_tvalid && dvd_tready;
    assign w_dvs_hs   = dvs_tvalid && dvs_tready;
    assign w_dvd_done = r_dvd_sent || w_dvd_hs;
    assign w_dvs_done = r_dvs_sent || w_dvs_hs;

    assign busy      = (r_state == DIV_ST_SEND) || (r_state == DIV_ST_WAIT) ||
                       (r_state == DIV_ST_DONE);
    assign done      = (r_state == DIV_ST_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_load_res    = 1'b0;
        w_set_flushed = 1'b0;
        case (r_state)
            DIV_ST_IDLE: begin
                if (req_valid && !flush) begin
                    w_accept     = 1'b1;
                    w_next_state = w_bypass ? DIV_ST_DONE : DIV_ST_SEND;
                end
            end
            DIV_ST_SEND: begin
                // Once any operand reached the IP it will produce a result
                // that must be swallowed, so a flush can no longer abort.
                if (w_dvd_done && w_dvs_done) begin
                    w_next_state = (flush || r_flushed) ? DIV_ST_DRAIN : DIV_ST_WAIT;
                end else if (flush) begin
                    if (!w_dvd_done && !w_dvs_done) begin
                        w_next_state = DIV_ST_IDLE;
                    end else begin
                        w_set_flushed = 1'b1;
                    end
                end
            end
            DIV_ST_WAIT: begin
                if (flush) begin
                    w_next_state = dout_tvalid ? DIV_ST_IDLE : DIV_ST_DRAIN;
                end else if (dout_tvalid) begin
                    w_load_res   = 1'b1;
                    w_next_state = DIV_ST_DONE;
                end
            end
            DIV_ST_DONE: begin
                if (flush || res_ack) begin
                    w_next_state = DIV_ST_IDLE;
                end
            end
            DIV_ST_DRAIN: begin
                if (dout_tvalid) begin
                    w_next_state = DIV_ST_IDLE;
                end
            end
            default: w_next_state = DIV_ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= DIV_ST_IDLE;
            r_dvd_sent  <= 1'b0;
            r_dvs_sent  <= 1'b0;
            r_flushed   <= 1'b0;
            r_sq        <= 1'b0;
            r_sr        <= 1'b0;
            r_dvd_data  <= '0;
            r_dvs_data  <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_dvd_sent <= 1'b0;
                r_dvs_sent <= 1'b0;
                r_flushed  <= 1'b0;
                r_sq       <= w_s1 ^ w_s2;
                r_sr       <= w_s1;
                r_dvd_data <= w_dvd_abs;
                r_dvs_data <= w_dvs_abs;
            end else begin
                if (w_dvd_hs)      r_dvd_sent <= 1'b1;
                if (w_dvs_hs)      r_dvs_sent <= 1'b1;
                if (w_set_flushed) r_flushed  <= 1'b1;
            end
            if (w_accept && w_bypass) begin
                r_quotient  <= '1;
                r_remainder <= req_src1;
            end else if (w_load_res) begin
                r_quotient  <= w_q_fix;
                r_remainder <= w_r_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a small capture-and-divide IP model.
// Define DIV_ZERO_BYPASS_EN for both bench and RTL to cover the bypass path.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_signed;
    logic [W-1:0]   req_src1;
    logic [W-1:0]   req_src2;
    logic           res_ack;
    logic           flush;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic [W-1:0]   dvd_tdata;
    logic           dvd_tvalid;
    logic           dvd_tready;
    logic [W-1:0]   dvs_tdata;
    logic           dvs_tvalid;
    logic           dvs_tready;
    logic [2*W-1:0] dout_tdata;
    logic           dout_tvalid;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] ip_dvd = '0;
    logic [W-1:0] ip_dvs = '0;
    int           n_dvd_hs = 0;
    int           n_dvs_hs = 0;
    int           hs_snap;

    always #5 clk = ~clk;

    div_seq_ctrl #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_signed  (req_signed),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .res_ack     (res_ack),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .dvd_tdata   (dvd_tdata),
        .dvd_tvalid  (dvd_tvalid),
        .dvd_tready  (dvd_tready),
        .dvs_tdata   (dvs_tdata),
        .dvs_tvalid  (dvs_tvalid),
        .dvs_tready  (dvs_tready),
        .dout_tdata  (dout_tdata),
        .dout_tvalid (dout_tvalid)
    );

    // IP model: capture operands on their handshakes.
    always @(posedge clk) begin
        if (dvd_tvalid && dvd_tready) begin
            ip_dvd   <= dvd_tdata;
            n_dvd_hs <= n_dvd_hs + 1;
        end
        if (dvs_tvalid && dvs_tready) begin
            ip_dvs   <= dvs_tdata;
            n_dvs_hs <= n_dvs_hs + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; the DUT is expected to be in IDLE.
    task automatic start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid  = 1'b1;
        req_signed = s;
        req_src1   = a;
        req_src2   = b;
        tick();
        req_valid  = 1'b0;
    endtask

    // Unsigned IP result from the captured operands after a latency.
    task automatic ip_respond(input int lat);
        repeat (lat) tick();
        dout_tdata  = {ip_dvd / ip_dvs, ip_dvd % ip_dvs};
        dout_tvalid = 1'b1;
        tick();
        dout_tvalid = 1'b0;
    endtask

    task automatic ack();
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_signed  = 1'b0;
        req_src1    = '0;
        req_src2    = '0;
        res_ack     = 1'b0;
        flush       = 1'b0;
        dvd_tready  = 1'b1;
        dvs_tready  = 1'b1;
        dout_tdata  = '0;
        dout_tvalid = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dvd_tvalid", 32'(dvd_tvalid), 32'd0);
        check("rst_dvs_tvalid", 32'(dvs_tvalid), 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        reset = 1'b0;
        tick();

        // DIVU 7 / 2
        start(1'b0, 32'd7, 32'd2);
        check("divu_busy", 32'(busy), 32'd1);
        check("divu_dvd_tvalid", 32'(dvd_tvalid), 32'd1);
        check("divu_dvs_tvalid", 32'(dvs_tvalid), 32'd1);
        check("divu_dvd_tdata", dvd_tdata, 32'd7);
        check("divu_dvs_tdata", dvs_tdata, 32'd2);
        tick();
        check("divu_wait_dvd_tvalid", 32'(dvd_tvalid), 32'd0);
        check("divu_wait_dvs_tvalid", 32'(dvs_tvalid), 32'd0);
        check("divu_wait_done", 32'(done), 32'd0);
        ip_respond(3);
        check("divu_done", 32'(done), 32'd1);
        check("divu_q", quotient, 32'd3);
        check("divu_r", remainder, 32'd1);
        ack();
        check("divu_idle_done", 32'(done), 32'd0);
        check("divu_idle_busy", 32'(busy), 32'd0);

        // DIV -7 / 2
        start(1'b1, 32'hFFFF_FFF9, 32'd2);
        tick();
        check("div_neg_ip_dvd", ip_dvd, 32'd7);
        check("div_neg_ip_dvs", ip_dvs, 32'd2);
        ip_respond(2);
        check("div_neg_q", quotient, 32'hFFFF_FFFD);
        check("div_neg_r", remainder, 32'hFFFF_FFFF);
        ack();

        // DIV 7 / -2
        start(1'b1, 32'd7, 32'hFFFF_FFFE);
        tick();
        check("div_negd_ip_dvs", ip_dvs, 32'd2);
        ip_respond(1);
        check("div_negd_q", quotient, 32'hFFFF_FFFD);
        check("div_negd_r", remainder, 32'd1);
        ack();

        // DIV most-negative / 1
        start(1'b1, 32'h8000_0000, 32'd1);
        check("div_min_dvd_tdata", dvd_tdata, 32'h8000_0000);
        tick();
        ip_respond(1);
        check("div_min_q", quotient, 32'h8000_0000);
        check("div_min_r", remainder, 32'd0);
        ack();

        // Divisor back-pressure: DIVU 20 / 3
        dvs_tready = 1'b0;
        start(1'b0, 32'd20, 32'd3);
        tick();
        check("bp_dvd_tvalid_drop", 32'(dvd_tvalid), 32'd0);
        check("bp_dvs_tvalid", 32'(dvs_tvalid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_dvs_tvalid_hold", 32'(dvs_tvalid), 32'd1);
            check("bp_dvs_tdata_hold", dvs_tdata, 32'd3);
            check("bp_dvd_tvalid_low", 32'(dvd_tvalid), 32'd0);
        end
        dvs_tready = 1'b1;
        tick();
        check("bp_dvs_tvalid_done", 32'(dvs_tvalid), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        ip_respond(2);
        check("bp_q", quotient, 32'd6);
        check("bp_r", remainder, 32'd2);
        ack();
        check("hs_dvd_count", 32'(n_dvd_hs), 32'd5);
        check("hs_dvs_count", 32'(n_dvs_hs), 32'd5);

        // Flush in SEND before any handshake
        dvd_tready = 1'b0;
        dvs_tready = 1'b0;
        hs_snap    = n_dvd_hs + n_dvs_hs;
        start(1'b0, 32'd50, 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fsend0_busy", 32'(busy), 32'd0);
        check("fsend0_dvd_tvalid", 32'(dvd_tvalid), 32'd0);
        check("fsend0_no_hs", 32'(n_dvd_hs + n_dvs_hs), 32'(hs_snap));

        // Flush in SEND after the dividend handshake
        dvd_tready = 1'b1;
        start(1'b0, 32'd50, 32'd5);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fsend1_busy", 32'(busy), 32'd1);
        check("fsend1_dvs_tvalid", 32'(dvs_tvalid), 32'd1);
        check("fsend1_dvs_tdata", dvs_tdata, 32'd5);
        dvs_tready = 1'b1;
        tick();
        check("fsend1_drain_busy", 32'(busy), 32'd0);
        check("fsend1_drain_dvs_tvalid", 32'(dvs_tvalid), 32'd0);
        ip_respond(2);
        check("fsend1_no_done", 32'(done), 32'd0);

        // Flush in WAIT, late stale result, new DIVU 9 / 4 waiting
        start(1'b0, 32'd100, 32'd7);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fwait_drain_busy", 32'(busy), 32'd0);
        req_valid  = 1'b1;
        req_signed = 1'b0;
        req_src1   = 32'd9;
        req_src2   = 32'd4;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("fwait_drain_ignore_req", 32'(busy), 32'd0);
            check("fwait_drain_no_done", 32'(done), 32'd0);
        end
        dout_tdata  = {32'd14, 32'd2};
        dout_tvalid = 1'b1;
        tick();
        dout_tvalid = 1'b0;
        check("fwait_stale_no_done", 32'(done), 32'd0);
        check("fwait_stale_idle", 32'(busy), 32'd0);
        tick();
        req_valid = 1'b0;
        check("fwait_new_busy", 32'(busy), 32'd1);
        check("fwait_new_dvd", dvd_tdata, 32'd9);
        check("fwait_new_dvs", dvs_tdata, 32'd4);
        tick();
        ip_respond(3);
        check("fwait_new_q", quotient, 32'd2);
        check("fwait_new_r", remainder, 32'd1);

        // Result held while res_ack is low
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_done", 32'(done), 32'd1);
            check("hold_q", quotient, 32'd2);
            check("hold_r", remainder, 32'd1);
        end
        ack();
        check("hold_ack_done", 32'(done), 32'd0);
        check("hold_ack_busy", 32'(busy), 32'd0);

        // Flush and dout_tvalid together in WAIT: back to IDLE directly
        start(1'b0, 32'd7, 32'd2);
        tick();
        flush       = 1'b1;
        dout_tdata  = {32'd3, 32'd1};
        dout_tvalid = 1'b1;
        tick();
        flush       = 1'b0;
        dout_tvalid = 1'b0;
        check("fsame_done", 32'(done), 32'd0);
        start(1'b0, 32'd9, 32'd4);
        check("fsame_next_accepted", 32'(busy), 32'd1);
        tick();
        ip_respond(1);
        check("fsame_next_q", quotient, 32'd2);
        ack();

        // Flush in DONE
        start(1'b0, 32'd7, 32'd2);
        tick();
        ip_respond(1);
        check("fdone_done", 32'(done), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fdone_dropped", 32'(done), 32'd0);
        check("fdone_busy", 32'(busy), 32'd0);

`ifdef DIV_ZERO_BYPASS_EN
        hs_snap = n_dvd_hs + n_dvs_hs;
        start(1'b0, 32'd5, 32'd0);
        check("byp_dvd_tvalid", 32'(dvd_tvalid), 32'd0);
        check("byp_dvs_tvalid", 32'(dvs_tvalid), 32'd0);
        check("byp_done", 32'(done), 32'd1);
        check("byp_q", quotient, 32'hFFFF_FFFF);
        check("byp_r", remainder, 32'd5);
        ack();
        check("byp_no_hs", 32'(n_dvd_hs + n_dvs_hs), 32'(hs_snap));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
